prefetch_unit: RTL and testbench

Parametrised instruction prefetcher that sits between the CPU core's decode stage and the shared arbitrated memory bus. It requests the bus with a grant handshake and fetches an instruction one bus word per grant, most significant beat first. It assembles each instruction and queues up to DEPTH complete instructions, with their PCs, for the core. A redirect input flushes the queue and restarts fetch at a new PC for jumps and taken branches.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/instr_fifo.sv | 54 +++++
 rtl/prefetch_unit.sv | 139 +++++++++++++
 tb/tb_prefetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction prefetcher.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } fetch_state_t;

  // Bus beats needed to assemble one instruction.
  function automatic int fetch_beats(input int instr_w, input int data_w);
    return instr_w / data_w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with flush; the head entry is readable whenever count is non-zero.
module instr_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: stale entries are never visible while count is zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: fetches one bus word per grant, MSB beat first,
// assembles instructions and queues them with their PCs for the core.
module prefetch_unit
  import fetch_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 10,
  parameter int PC_W    = 8,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     grant_request,
  input  logic                     grant_given,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic                     bus_rw,
  input  logic [DATA_W-1:0]        bus_rdata,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_pc,
  output logic                     instr_valid,
  output logic [INSTR_W-1:0]       instr,
  output logic [PC_W-1:0]          instr_pc,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int BEATS   = fetch_beats(INSTR_W, DATA_W);
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = INSTR_W + PC_W;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  fetch_state_t       state;
  fetch_state_t       state_next;
  logic [PC_W-1:0]    fetch_pc;
  logic [PC_W-1:0]    start_pc;
  logic [BEAT_W-1:0]  beat_idx;
  logic [INSTR_W-1:0] asm_buf;
  logic [INSTR_W-1:0] asm_next;
  logic               grant_fire;
  logic               last_beat;
  logic               push;
  logic               pop;
  logic               slot_free;
  logic [CNT_W-1:0]   count_after;
  entry_t             push_entry;
  entry_t             head_entry;
  logic [ENTRY_W-1:0] head_bits;
  logic               fifo_empty;
  logic               fifo_full;

  assign grant_fire  = (state == REQ) && grant_given && !redirect;
  assign last_beat   = (beat_idx == BEAT_W'(BEATS - 1));
  assign push        = grant_fire && last_beat;
  assign pop         = instr_valid && instr_ready && !redirect;
  assign count_after = count - CNT_W'(pop);
  assign slot_free   = (count_after < CNT_W'(DEPTH));

  always_comb begin
    asm_next = asm_buf;
    asm_next[(BEATS - 1 - int'(beat_idx)) * DATA_W +: DATA_W] = bus_rdata;
  end

  // The push carries the beat being granted now, so it bypasses asm_buf.
  always_comb begin
    push_entry.instr = asm_next;
    push_entry.pc    = (beat_idx == '0) ? fetch_pc : start_pc;
  end

  always_comb begin
    state_next = state;
    if (redirect) begin
      state_next = REL;
    end else begin
      case (state)
        IDLE:    if (slot_free) state_next = REQ;
        REQ:     if (grant_given) state_next = REL;
        // beat_idx==0 here means the next request starts a new instruction.
        REL:     state_next = (beat_idx != '0 || slot_free) ? REQ : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= '0;
      start_pc <= '0;
      beat_idx <= '0;
      asm_buf  <= '0;
    end else begin
      state <= state_next;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        start_pc <= redirect_pc;
        beat_idx <= '0;
      end else if (grant_fire) begin
        asm_buf  <= asm_next;
        fetch_pc <= fetch_pc + PC_W'(1);
        if (beat_idx == '0) start_pc <= fetch_pc;
        beat_idx <= last_beat ? '0 : beat_idx + BEAT_W'(1);
      end
    end
  end

  instr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head_data (head_bits),
    .count     (count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign head_entry    = entry_t'(head_bits);
  assign instr_valid   = !fifo_empty;
  assign instr         = instr_valid ? head_entry.instr : '0;
  assign instr_pc      = instr_valid ? head_entry.pc : '0;
  assign grant_request = (state == REQ);
  assign bus_addr      = ADDR_W'(fetch_pc);
  assign bus_rw        = 1'b0;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed self-checking bench for prefetch_unit with default parameters (BEATS=4, DEPTH=4).
module tb_prefetch_unit;

  logic        clk;
  logic        reset;
  logic        grant_request;
  logic        grant_given;
  logic [9:0]  bus_addr;
  logic        bus_rw;
  logic [7:0]  bus_rdata;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_ready;
  logic [2:0]  count;

  logic [7:0]  mem [1024];
  int          total;
  int          bad;
  int          cyc;

  prefetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .grant_request (grant_request),
    .grant_given   (grant_given),
    .bus_addr      (bus_addr),
    .bus_rw        (bus_rw),
    .bus_rdata     (bus_rdata),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .count         (count)
  );

  assign bus_rdata = mem[bus_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    instr_ready = 1'b0;
    grant_given = 1'b1;
    step();
    step();
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    mem[0] = 8'h12;
    mem[1] = 8'h34;
    mem[2] = 8'h56;
    mem[3] = 8'h78;

    // Reset values, then back-to-back fetch with an always-granting bus.
    reset = 1'b1;
    redirect = 1'b0;
    redirect_pc = 8'h00;
    instr_ready = 1'b0;
    grant_given = 1'b1;
    step();
    step();
    check("rst_greq",   64'(grant_request), 64'd0);
    check("rst_addr",   64'(bus_addr),      64'd0);
    check("rst_rw",     64'(bus_rw),        64'd0);
    check("rst_valid",  64'(instr_valid),   64'd0);
    check("rst_instr",  64'(instr),         64'd0);
    check("rst_pc",     64'(instr_pc),      64'd0);
    check("rst_count",  64'(count),         64'd0);
    reset = 1'b0;
    cyc = 0;
    check("c0_greq", 64'(grant_request), 64'd0);
    for (int c = 1; c <= 8; c++) begin
      step();
      check($sformatf("c%0d_greq", c), 64'(grant_request), 64'(c % 2));
      check($sformatf("c%0d_addr", c), 64'(bus_addr),      64'(c / 2));
      if (c == 7) check("c7_valid", 64'(instr_valid), 64'd0);
    end
    check("c8_valid", 64'(instr_valid), 64'd1);
    check("c8_instr", 64'(instr),       64'h12345678);
    check("c8_pc",    64'(instr_pc),    64'd0);
    check("c8_count", 64'(count),       64'd1);

    // Core stalls: queue fills to 4 and fetch parks in IDLE.
    go_to(34);
    check("full_count", 64'(count),         64'd4);
    check("full_greq",  64'(grant_request), 64'd0);
    check("full_addr",  64'(bus_addr),      64'd16);
    check("full_instr", 64'(instr),         64'h12345678);
    check("full_pc",    64'(instr_pc),      64'd0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("pop_count", 64'(count),         64'd3);
    check("pop_greq",  64'(grant_request), 64'd1);
    check("pop_addr",  64'(bus_addr),      64'd16);
    check("pop_instr", 64'(instr),         64'h04050607);
    check("pop_pc",    64'(instr_pc),      64'd4);

    // Grant withheld for 5 cycles on beat 2.
    do_reset();
    go_to(5);
    grant_given = 1'b0;
    for (int c = 5; c <= 9; c++) begin
      check($sformatf("dly%0d_greq", c), 64'(grant_request), 64'd1);
      check($sformatf("dly%0d_addr", c), 64'(bus_addr),      64'd2);
      step();
    end
    grant_given = 1'b1;
    go_to(12);
    check("dly_valid12", 64'(instr_valid), 64'd0);
    step();
    check("dly_valid13", 64'(instr_valid), 64'd1);
    check("dly_instr",   64'(instr),       64'h12345678);
    check("dly_pc",      64'(instr_pc),    64'd0);

    // Redirect during beat-2 grant with two instructions queued; concurrent pop ignored.
    do_reset();
    go_to(21);
    check("rd_pre_count", 64'(count),         64'd2);
    check("rd_pre_greq",  64'(grant_request), 64'd1);
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    instr_ready = 1'b1;
    step();
    redirect    = 1'b0;
    instr_ready = 1'b0;
    check("rd_count", 64'(count),         64'd0);
    check("rd_valid", 64'(instr_valid),   64'd0);
    check("rd_greq",  64'(grant_request), 64'd0);
    step();
    check("rd_req_greq", 64'(grant_request), 64'd1);
    check("rd_req_addr", 64'(bus_addr),      64'h40);
    go_to(29);
    check("rd_valid29", 64'(instr_valid), 64'd0);
    step();
    check("rd_valid30", 64'(instr_valid), 64'd1);
    check("rd_pc",      64'(instr_pc),    64'h40);
    check("rd_instr",   64'(instr),       64'h40414243);
    check("rd_count30", 64'(count),       64'd1);

    // PC wrap: redirect to 0xFE right after reset.
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 8'hFE;
    step();
    redirect = 1'b0;
    check("wr_greq1", 64'(grant_request), 64'd0);
    go_to(2);
    check("wr_addr2", 64'(bus_addr), 64'h0FE);
    go_to(4);
    check("wr_addr4", 64'(bus_addr), 64'h0FF);
    go_to(6);
    check("wr_addr6", 64'(bus_addr), 64'h000);
    go_to(8);
    check("wr_addr8", 64'(bus_addr), 64'h001);
    check("wr_greq8", 64'(grant_request), 64'd1);
    step();
    check("wr_valid", 64'(instr_valid), 64'd1);
    check("wr_pc",    64'(instr_pc),    64'hFE);
    check("wr_instr", 64'(instr),       64'hFEFF1234);

    // Reset asserted mid-handshake with one instruction queued.
    do_reset();
    go_to(9);
    grant_given = 1'b0;
    check("mr_pre_greq",  64'(grant_request), 64'd1);
    check("mr_pre_count", 64'(count),         64'd1);
    reset = 1'b1;
    step();
    check("mr_greq",  64'(grant_request), 64'd0);
    check("mr_count", 64'(count),         64'd0);
    check("mr_valid", 64'(instr_valid),   64'd0);
    reset       = 1'b0;
    grant_given = 1'b1;
    cyc = 0;
    step();
    check("mr_restart_greq", 64'(grant_request), 64'd1);
    check("mr_restart_addr", 64'(bus_addr),      64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
